// File: rtl/duck_round_ctrl.sv
// duck_round_ctrl: game sequencer for the duck sprite block (ready/fly/result cycle plus
// bullet, hit, score and round bookkeeping). Optional perfect-round bonus: DUCK_ROUND_CTRL_PERFECT_BONUS_EN.
module duck_round_ctrl #(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int BULLETS         = 3,
  parameter int HITS_TO_PASS    = 6,
  parameter int READY_FRAMES    = 120,
  parameter int RESULT_FRAMES   = 60,
  parameter int FLY_TIMEOUT     = 600,
  parameter int POINTS_PER_HIT  = 500
`ifdef DUCK_ROUND_CTRL_PERFECT_BONUS_EN
  ,
  parameter int PERFECT_BONUS   = 10000
`endif
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        start,
  input  logic        trigger,
  input  logic        on_duck,
  input  logic        flew_away,
  input  logic        bird_shot,
  output logic [1:0]  state,
  output logic        shot,
  output logic [2:0]  bullets_left,
  output logic [3:0]  ducks_left,
  output logic [3:0]  hits,
  output logic [6:0]  round_num,
  output logic [19:0] score,
  output logic        game_over
);

  localparam logic [19:0] SCORE_MAX = 20'd999999;
  localparam logic [6:0]  ROUND_MAX = 7'd99;
  localparam int CNT_MAX = (FLY_TIMEOUT > READY_FRAMES)
                         ? ((FLY_TIMEOUT > RESULT_FRAMES) ? FLY_TIMEOUT : RESULT_FRAMES)
                         : ((READY_FRAMES > RESULT_FRAMES) ? READY_FRAMES : RESULT_FRAMES);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READY, S_FLY, S_RESULT, S_ROUND_END, S_GAME_OVER
  } fsm_e;

  fsm_e fsm_q, fsm_d;

  logic             fclk_prev_q;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]       state_q, state_d;
  logic             shot_q, shot_d;
  logic [2:0]       bullets_left_q, bullets_left_d;
  logic [3:0]       ducks_left_q, ducks_left_d;
  logic [3:0]       hits_q, hits_d;
  logic [6:0]       round_num_q, round_num_d;
  logic [19:0]      score_q, score_d;
  logic             game_over_q, game_over_d;

  logic ready_done, result_done, fly_timeout, fly_miss, fly_exit, round_pass;

  function automatic logic [19:0] sat_add(input logic [19:0] a, input logic [19:0] b);
    logic [20:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[19:0];
  endfunction

  always_comb begin
    tick_d      = frame_clk & ~fclk_prev_q;
    ready_done  = tick_q && (frame_cnt_q == CNT_W'(READY_FRAMES - 1));
    result_done = tick_q && (frame_cnt_q == CNT_W'(RESULT_FRAMES - 1));
    fly_timeout = tick_q && (frame_cnt_q == CNT_W'(FLY_TIMEOUT - 1));
    // A simultaneous flew_away and bird_shot is scored as a miss
    fly_miss    = flew_away | fly_timeout;
    fly_exit    = fly_miss | bird_shot;
    round_pass  = (hits_q >= 4'(HITS_TO_PASS));
  end

  always_ff @(posedge Clk) begin
    if (Reset) fsm_q <= S_IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE, S_GAME_OVER: if (start)       fsm_d = S_READY;
      S_READY:             if (ready_done)  fsm_d = S_FLY;
      S_FLY:               if (fly_exit)    fsm_d = S_RESULT;
      S_RESULT:            if (result_done) fsm_d = (ducks_left_q == 4'd1) ? S_ROUND_END : S_READY;
      S_ROUND_END:         if (ready_done)  fsm_d = round_pass ? S_READY : S_GAME_OVER;
      default:             fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    shot_d         = shot_q;
    bullets_left_d = bullets_left_q;
    ducks_left_d   = ducks_left_q;
    hits_d         = hits_q;
    round_num_d    = round_num_q;
    score_d        = score_q;
    game_over_d    = game_over_q;

    if (fsm_d != fsm_q)
      frame_cnt_d = '0;
    else if (tick_q)
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    else
      frame_cnt_d = frame_cnt_q;

    case (fsm_d)
      S_READY, S_ROUND_END: state_d = 2'b01;
      S_FLY:                state_d = 2'b10;
      S_RESULT:             state_d = 2'b11;
      default:              state_d = 2'b00;
    endcase

    case (fsm_q)
      S_IDLE, S_GAME_OVER: begin
        if (start) begin
          score_d      = '0;
          hits_d       = '0;
          ducks_left_d = 4'(DUCKS_PER_ROUND);
          round_num_d  = 7'd1;
          game_over_d  = 1'b0;
        end
      end
      S_READY: begin
        if (ready_done) begin
          bullets_left_d = 3'(BULLETS);
          shot_d         = 1'b0;
        end
      end
      S_FLY: begin
        // Leaving FLY takes priority over any trigger in the same cycle
        if (fly_miss) begin
          shot_d = 1'b0;
        end else if (bird_shot) begin
          hits_d  = hits_q + 4'd1;
          score_d = sat_add(score_q, 20'(POINTS_PER_HIT));
          shot_d  = 1'b0;
        end else if (trigger && (bullets_left_q != 3'd0)) begin
          bullets_left_d = bullets_left_q - 3'd1;
          if (on_duck) shot_d = 1'b1;
        end
      end
      S_RESULT: begin
        if (result_done) ducks_left_d = ducks_left_q - 4'd1;
      end
      S_ROUND_END: begin
        if (ready_done) begin
`ifdef DUCK_ROUND_CTRL_PERFECT_BONUS_EN
          if (hits_q == 4'(DUCKS_PER_ROUND)) score_d = sat_add(score_q, 20'(PERFECT_BONUS));
`endif
          if (round_pass) begin
            round_num_d  = (round_num_q >= ROUND_MAX) ? ROUND_MAX : round_num_q + 7'd1;
            hits_d       = '0;
            ducks_left_d = 4'(DUCKS_PER_ROUND);
          end else begin
            game_over_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fclk_prev_q    <= 1'b0;
      tick_q         <= 1'b0;
      frame_cnt_q    <= '0;
      state_q        <= 2'b00;
      shot_q         <= 1'b0;
      bullets_left_q <= 3'(BULLETS);
      ducks_left_q   <= 4'(DUCKS_PER_ROUND);
      hits_q         <= '0;
      round_num_q    <= 7'd1;
      score_q        <= '0;
      game_over_q    <= 1'b0;
    end else begin
      fclk_prev_q    <= frame_clk;
      tick_q         <= tick_d;
      frame_cnt_q    <= frame_cnt_d;
      state_q        <= state_d;
      shot_q         <= shot_d;
      bullets_left_q <= bullets_left_d;
      ducks_left_q   <= ducks_left_d;
      hits_q         <= hits_d;
      round_num_q    <= round_num_d;
      score_q        <= score_d;
      game_over_q    <= game_over_d;
    end
  end

  assign state        = state_q;
  assign shot         = shot_q;
  assign bullets_left = bullets_left_q;
  assign ducks_left   = ducks_left_q;
  assign hits         = hits_q;
  assign round_num    = round_num_q;
  assign score        = score_q;
  assign game_over    = game_over_q;

endmodule
